// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word per frame from a show-ahead FIFO and
// sends it as start(0), DATA_WIDTH data bits LSB first, stop(1).
module fifo_uart_tx #(
    parameter int DATA_WIDTH      = 8,
    parameter int CLOCKS_PER_BAUD = 1085
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [CNT_W-1:0]      baud_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      bit_idx_nxt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  serial_nxt;
    logic                  bit_end;

    assign bit_end     = (baud_cnt == CNT_LAST);
    assign bit_idx_nxt = bit_idx + IDX_W'(1);

    // The pop is only offered from IDLE, so at most one word is in flight.
    assign fifo_rd_en = (state == IDLE) && tx_en && !fifo_empty;
    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && bit_end;

    // serial_nxt is the line level for the coming cycle, so serial_out is
    // registered and changes exactly on bit boundaries.
    always_comb begin
        // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
        state_nxt  = state;
        serial_nxt = serial_out;
        case (state)
            IDLE: begin
                serial_nxt = 1'b1;
                if (fifo_rd_en) begin
                    state_nxt  = START;
                    serial_nxt = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt  = DATA;
                    serial_nxt = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        state_nxt  = STOP;
                        serial_nxt = 1'b1;
                    end else begin
                        serial_nxt = shift_reg[bit_idx_nxt];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt  = IDLE;
                    serial_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                serial_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state      <= state_nxt;
            serial_out <= serial_nxt;

            if (fifo_rd_en) begin
                shift_reg <= fifo_dout;
            end

            if (state == IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            // Index only advances in DATA; it re-arms at 0 for the next frame.
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= bit_idx_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: frame-level reference model, a queue-based
// FIFO, and an independent UART decoder, with directed and randomized stimulus.
module tb_fifo_uart_tx;

    localparam int DW        = 8;
    localparam int CPB       = 4;
    localparam int FRAME_LEN = (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          serial_out;
    logic          busy;
    logic          frame_done;

    fifo_uart_tx #(
        .DATA_WIDTH      (DW),
        .CLOCKS_PER_BAUD (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .serial_out (serial_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pops    = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] rx_q[$];

    // Model: cycles left in the current frame (0 = idle) and the word being sent.
    int            m_remaining = 0;
    logic [DW-1:0] m_word = '0;

    logic          rx_active = 1'b0;
    int            rx_cnt = 0;
    logic [DW-1:0] rx_word = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_line(input int rem, input logic [DW-1:0] w);
        int pos;
        int bit_no;
        if (rem == 0) return 1'b1;
        pos    = FRAME_LEN - rem;
        bit_no = pos / CPB;
        if (bit_no == 0) return 1'b0;
        if (bit_no <= DW) return w[bit_no-1];
        return 1'b1;
    endfunction

    // Empty FIFO presents garbage on dout to prove it is ignored.
    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? DW'($urandom) : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        sent_q.push_back(w);
        drive_fifo();
    endtask

    task automatic rx_sample(input logic line);
        int k;
        if (!rx_active && line == 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
        end
        if (rx_active) begin
            if (rx_cnt % CPB == CPB / 2) begin
                k = rx_cnt / CPB;
                if (k >= 1 && k <= DW) begin
                    rx_word[k-1] = line;
                end else if (k == DW + 1) begin
                    check("stop_bit", 32'(line), 32'd1);
                    rx_q.push_back(rx_word);
                    rx_active = 1'b0;
                end
            end
            rx_cnt++;
        end
    endtask

    // One clock: compare at negedge, then advance model and FIFO just after posedge.
    task automatic cycle();
        logic exp_pop;
        logic dut_pop;
        @(negedge clk);
        exp_pop = (m_remaining == 0) && tx_en && (fifo_q.size() != 0);
        check("serial_out", 32'(serial_out), 32'(model_line(m_remaining, m_word)));
        check("busy", 32'(busy), 32'(m_remaining != 0));
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_pop));
        check("frame_done", 32'(frame_done), 32'(m_remaining == 1));
        rx_sample(serial_out);
        dut_pop = fifo_rd_en;
        @(posedge clk);
        #1;
        if (m_remaining > 0) begin
            m_remaining--;
        end else if (exp_pop) begin
            m_remaining = FRAME_LEN;
            m_word      = fifo_q[0];
        end
        if (dut_pop) begin
            pops++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        drive_fifo();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_frames(input string tag, input int exp_pops);
        check({tag, "_pops"}, 32'(pops), 32'(exp_pops));
        check({tag, "_frames"}, 32'(rx_q.size()), 32'(sent_q.size()));
        for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++) begin
            check({tag, "_byte"}, 32'(rx_q[i]), 32'(sent_q[i]));
        end
        pops = 0;
        rx_q.delete();
        sent_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        tx_en = 1'b1;
        drive_fifo();

        // Reset and idle
        #12;
        check("rst_serial", 32'(serial_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(100);
        check_frames("idle", 0);

        // Single byte
        push(8'hA5);
        run(FRAME_LEN + 10);
        check_frames("a5", 1);

        // Back-to-back preloaded words
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        run(3 * (FRAME_LEN + 1) + 10);
        check_frames("b2b", 3);

        // tx_en gating
        tx_en = 1'b0;
        push(8'h3C);
        run(50);
        check("gate_no_pop", 32'(pops), 32'd0);
        tx_en = 1'b1;
        run(FRAME_LEN + 10);
        check_frames("gate", 1);

        // tx_en dropped during data bit 3; a second word stays queued
        push(8'h81);
        push(8'h42);
        run(1 + CPB + 3 * CPB + 2);
        tx_en = 1'b0;
        run(FRAME_LEN + 20);
        check("txoff_pops", 32'(pops), 32'd1);
        check("txoff_frames", 32'(rx_q.size()), 32'd1);
        tx_en = 1'b1;
        run(FRAME_LEN + 10);
        check_frames("txoff", 2);

        // Asynchronous reset during data bit 5
        push(8'h99);
        run(1 + CPB + 5 * CPB + 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_serial", 32'(serial_out), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_frame_done", 32'(frame_done), 32'd0);
        m_remaining = 0;
        rx_active   = 1'b0;
        pops        = 0;
        rx_q.delete();
        sent_q.delete();
        run(3);
        rst_n = 1'b1;
        push(8'h12);
        run(FRAME_LEN + 10);
        check_frames("post_reset", 1);

        // Randomized traffic with random tx_en toggling
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 19) == 0 && fifo_q.size() < 6) push(DW'($urandom));
            if ($urandom_range(0, 79) == 0) tx_en = ~tx_en;
            cycle();
        end
        tx_en = 1'b1;
        run(8 * (FRAME_LEN + 1) + 10);
        check("random_drained", 32'(fifo_q.size()), 32'd0);
        check_frames("random", sent_q.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
